// File: rtl/rob_ctrl_pkg.sv
// Shared constants and types for the reorder-buffer pointer controller.
// A ROB id is {wrap bit, row index}.
package rob_ctrl_pkg;

  localparam int ROW_NUM  = 128;
  localparam int BANK_NUM = 4;
  localparam int RW       = $clog2(ROW_NUM);
  localparam int ID_W     = RW + 1;
  localparam int BANK_W   = $clog2(BANK_NUM);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  typedef logic [ID_W-1:0] rob_id_t;

endpackage

// File: rtl/rob_ctrl_if.sv
// Dispatch / head-row / commit bundle between the ROB controller and its neighbours.
// The controller is the slave; dispatch, storage and the redirect source are the master.
interface rob_ctrl_if;
  import rob_ctrl_pkg::*;

  logic                alloc_req;
  logic [BANK_NUM-1:0] alloc_mask;
  logic                alloc_gnt;
  rob_id_t             alloc_id;

  logic [RW-1:0]       head_row;
  logic [BANK_NUM-1:0] head_vmask;
  logic [BANK_NUM-1:0] head_rdymask;
  logic [BANK_NUM-1:0] head_excmask;

  logic                redirect_req;
  rob_id_t             redirect_id;

  logic                commit_valid;
  logic [BANK_NUM-1:0] commit_mask;
  logic [RW-1:0]       commit_row;
  logic                exc_valid;
  logic [BANK_W-1:0]   exc_bank;
  logic [RW-1:0]       exc_row;
  logic                flush;
  logic                empty;
  logic                full;
  logic [RW:0]         occupancy;

  modport master (
    output alloc_req, alloc_mask, head_vmask, head_rdymask, head_excmask,
           redirect_req, redirect_id,
    input  alloc_gnt, alloc_id, head_row, commit_valid, commit_mask, commit_row,
           exc_valid, exc_bank, exc_row, flush, empty, full, occupancy
  );

  modport slave (
    input  alloc_req, alloc_mask, head_vmask, head_rdymask, head_excmask,
           redirect_req, redirect_id,
    output alloc_gnt, alloc_id, head_row, commit_valid, commit_mask, commit_row,
           exc_valid, exc_bank, exc_row, flush, empty, full, occupancy
  );

endinterface

// File: rtl/rob_commit_sel.sv
// Head-row commit decision: finds the oldest excepting bank and decides whether
// the row (or the part of it below the exception) can retire this cycle.
module rob_commit_sel
  import rob_ctrl_pkg::*;
#(
  parameter int NB = BANK_NUM
) (
  input  logic [NB-1:0]         vmask_i,
  input  logic [NB-1:0]         rdy_i,
  input  logic [NB-1:0]         exc_i,
  output logic                  exc_o,
  output logic [$clog2(NB)-1:0] bank_o,
  output logic                  take_o,
  output logic [NB-1:0]         mask_o
);

  logic [NB-1:0] hit;
  logic [NB-1:0] low;
  logic [NB-1:0] below;
  logic [NB-1:0] upto;

  // With no exception low is zero, so below/upto become all-ones and the
  // same equations reduce to "every valid bank ready, commit all valid banks".
  assign hit   = vmask_i & exc_i;
  assign low   = hit & (~hit + NB'(1));
  assign below = low - NB'(1);
  assign upto  = below | low;

  assign exc_o  = |hit;
  assign take_o = ~|(vmask_i & ~rdy_i & upto);
  assign mask_o = vmask_i & below;

  always_comb begin
    bank_o = '0;
    for (int i = NB - 1; i >= 0; i--) begin
      if (hit[i]) bank_o = ($clog2(NB))'(i);
    end
  end

endmodule

// File: rtl/rob_ctrl.sv
// ROB head/tail pointer controller: allocation, in-order commit, exception flush
// and branch-redirect tail truncation.
module rob_ctrl #(
  parameter int ROW_NUM  = rob_ctrl_pkg::ROW_NUM,
  parameter int BANK_NUM = rob_ctrl_pkg::BANK_NUM,
  parameter int ID_W     = rob_ctrl_pkg::ID_W
) (
  input  logic      clk,
  input  logic      rst,
  rob_ctrl_if.slave bus
);
  import rob_ctrl_pkg::*;

  localparam int IDX_W = $clog2(ROW_NUM);
  localparam int BW    = $clog2(BANK_NUM);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic                commit_valid_q, exc_valid_q;
  logic [BANK_NUM-1:0] commit_mask_q;
  logic [IDX_W-1:0]    commit_row_q, exc_row_q;
  logic [BW-1:0]       exc_bank_q;

  logic                sel_exc, sel_take;
  logic [BW-1:0]       sel_bank;
  logic [BANK_NUM-1:0] sel_mask;

  logic [ID_W-1:0]     occ, redir_off;
  logic                run, empty_w, full_w, flush_w;
  logic                commit_take, exc_take, alloc_gnt_w, redir_ok;

  rob_commit_sel #(.NB(BANK_NUM)) u_sel (
    .vmask_i (bus.head_vmask),
    .rdy_i   (bus.head_rdymask),
    .exc_i   (bus.head_excmask),
    .exc_o   (sel_exc),
    .bank_o  (sel_bank),
    .take_o  (sel_take),
    .mask_o  (sel_mask)
  );

  assign occ     = tail_q - head_q;
  assign empty_w = (head_q == tail_q);
  assign full_w  = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign run     = (state_q == ST_RUN);

  assign commit_take = run & ~empty_w & sel_take;
  assign exc_take    = commit_take & sel_exc;
  // Full is judged on registered pointers only; a same-cycle commit does not free a slot.
  assign alloc_gnt_w = bus.alloc_req & (|bus.alloc_mask) & ~full_w & run
                     & ~bus.redirect_req & ~exc_take;
  assign redir_off   = bus.redirect_id - head_q;
  assign redir_ok    = bus.redirect_req & run & ~exc_take & (redir_off < occ);

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (exc_take) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    flush_w = (state_q == ST_FLUSH);
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (state_q == ST_FLUSH) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (commit_take) head_d = head_q + ID_W'(1);
      if (redir_ok)         tail_d = bus.redirect_id + ID_W'(1);
      else if (alloc_gnt_w) tail_d = tail_q + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_mask_q  <= '0;
      commit_row_q   <= '0;
      exc_valid_q    <= 1'b0;
      exc_bank_q     <= '0;
      exc_row_q      <= '0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      commit_valid_q <= commit_take;
      commit_mask_q  <= commit_take ? sel_mask : '0;
      exc_valid_q    <= exc_take;
      if (commit_take) commit_row_q <= head_q[IDX_W-1:0];
      if (exc_take) begin
        exc_bank_q <= sel_bank;
        exc_row_q  <= head_q[IDX_W-1:0];
      end
    end
  end

  assign bus.alloc_gnt    = alloc_gnt_w;
  assign bus.alloc_id     = tail_q;
  assign bus.head_row     = head_q[IDX_W-1:0];
  assign bus.commit_valid = commit_valid_q;
  assign bus.commit_mask  = commit_mask_q;
  assign bus.commit_row   = commit_row_q;
  assign bus.exc_valid    = exc_valid_q;
  assign bus.exc_bank     = exc_bank_q;
  assign bus.exc_row      = exc_row_q;
  assign bus.flush        = flush_w;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.occupancy    = occ;

endmodule

// File: doc/rob_ctrl.md
ROB_CTRL -- requirements
Module: rob_ctrl

Interface
REQ-001 SHALL have parameter ROW_NUM, 128, number of ROB rows (power of 2); row index width RW = log2(ROW_NUM) = 7.
REQ-002 SHALL have parameter BANK_NUM, 4, banks per row (one dispatch slot per bank).
REQ-003 SHALL have parameter ID_W, RW+1 = 8, ROB id = {wrap bit, row index}.
REQ-004 clk  in  1  sole clock; all state updates on posedge.
REQ-005 rst  in  1  reset; synchronous, active-low.
REQ-006 alloc_req  in  1  dispatch requests one row.
REQ-007 alloc_mask  in  BANK_NUM  banks occupied by the dispatched group.
REQ-008 alloc_gnt  out  1  row granted this cycle (combinational).
REQ-009 alloc_id  out  ID_W  tail id granted (valid with alloc_gnt).
REQ-010 head_row  out  RW  registered head index, drives ROB storage read index.
REQ-011 head_vmask / head_rdymask / head_excmask  in  BANK_NUM each  valid / rdy / hasException bits of the head row, same cycle.
REQ-012 redirect_req  in  1  branch mispredict; redirect_id  in  ID_W  id of the mispredicted row.
REQ-013 commit_valid  out  1; commit_mask  out  BANK_NUM; commit_row  out  RW; all registered.
REQ-014 exc_valid  out  1; exc_bank  out  2; exc_row  out  RW; registered, one-cycle pulse.
REQ-015 flush  out  1  full pipeline flush, one-cycle pulse.
REQ-016 empty  out  1; full  out  1; occupancy  out  RW+1  rows in use (0..ROW_NUM).

Function
REQ-017 SHALL keep head_ptr, tail_ptr of ID_W bits; empty = (head==tail); full = equal index, differing wrap bit; occupancy = tail-head mod 2*ROW_NUM.
REQ-018 alloc_gnt SHALL = alloc_req & |alloc_mask & ~full & state==RUN & ~redirect_req & ~exc_take; on gnt alloc_id = tail_ptr, tail_ptr increments at the edge.
REQ-019 Allocation SHALL NOT use a same-cycle commit to relieve full.
REQ-020 Commit decision SHALL be combinational on head inputs when ~empty and state==RUN: e = lowest bank with vmask&excmask; if none, take when every vmask bank has rdy, commit_mask = vmask.
REQ-021 If e exists, SHALL take (exc_take) when all vmask banks <= e are rdy; commit_mask = vmask banks below e; exc_bank = e; next state FLUSH.
REQ-022 A taken head row SHALL advance head_ptr at the edge and drive commit_valid/mask/row (and exc_* if exc_take) for exactly the following cycle (latency 1).
REQ-023 A head row with vmask==0 SHALL commit with commit_mask 0 (no deadlock).
REQ-024 States: RUN, FLUSH. RUN -> FLUSH on exc_take; FLUSH -> RUN after one cycle; in FLUSH flush=1, head_ptr=tail_ptr=0 at the edge, no alloc, no commit.
REQ-025 redirect_req in RUN with redirect_id inside [head, tail) SHALL set tail_ptr = redirect_id+1 (mod 2*ROW_NUM); out-of-range ids SHALL be ignored.
REQ-026 Same cycle: exc_take beats redirect_req (redirect dropped); redirect beats alloc; commit and redirect both apply (head advance, tail truncate).
REQ-027 Pointer increment SHALL wrap index ROW_NUM-1 -> 0 and toggle the wrap bit.

Reset
REQ-028 rst low at posedge SHALL force state RUN, head_ptr=tail_ptr=0, commit_valid=exc_valid=flush=0, commit_mask=0, commit_row=exc_row=exc_bank=0; empty=1, full=0, occupancy=0.
REQ-029 Reset mid-FLUSH or mid-commit SHALL abandon it; no pulse after release.

Structure
REQ-030 Package rob_ctrl_pkg SHALL hold ROW_NUM, BANK_NUM, ID_W, the state enum and the rob-id type.
REQ-031 Sub-module rob_commit_sel (combinational: e, exc present, take, commit_mask from the three head masks) SHALL be separate.

Verification
REQ-032 128 grants of mask 4'b1111 from reset, no commit -> full=1 after 128th, alloc_id 0x00..0x7F, 129th not granted.
REQ-033 Head vmask 1111, rdy 1011 then 1111 -> no commit, then commit_valid one cycle later, mask 1111, row 0, head_row 1.
REQ-034 Head vmask 1111, exc 0100, rdy 0111 -> commit_mask 0011, exc_valid, exc_bank 2; flush next cycle; then empty=1, alloc_id 0x00.
REQ-035 Rows 0..9 allocated, redirect_id 0x04 -> tail 0x05, occupancy 5; redirect_id 0x0C ignored.
REQ-036 Fill/commit 200 rows continuously -> alloc_id wraps 0x7F -> 0x80, occupancy never exceeds 128, no lost commits.
REQ-037 rst low during FLUSH cycle -> all outputs at reset values next cycle, no flush/exc pulse after release.
